ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, meaning RAM address width (512 words).
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning RAM data width.
REQ-003 The block SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port wr_req  input  2  per-requester write request.
REQ-006 The block SHALL have port wr_addr0/wr_addr1  input  ADDR_W  write address of requester 0/1.
REQ-007 The block SHALL have port wr_data0/wr_data1  input  DATA_W  write data of requester 0/1.
REQ-008 The block SHALL have port wr_gnt  output  2  one-hot write grant, same cycle as accepted request.
REQ-009 The block SHALL have port rd_req  input  2  per-requester read request.
REQ-010 The block SHALL have port rd_addr0/rd_addr1  input  ADDR_W  read address of requester 0/1.
REQ-011 The block SHALL have port rd_gnt  output  2  one-hot read grant.
REQ-012 The block SHALL have port rd_valid  output  2  read data valid, tagged to the owning requester.
REQ-013 The block SHALL have port rd_data  output  DATA_W  read data shared by both requesters.
REQ-014 The block SHALL have ports ram_wea  output  1, ram_addra  output  ADDR_W, ram_dina  output  DATA_W  to RAM write port A.
REQ-015 The block SHALL have ports ram_addrb  output  ADDR_W  and ram_doutb  input  DATA_W  to RAM read port B (RAM read latency 1 cycle).

Function
REQ-016 Handshake: requester holds req, addr and data stable until gnt; gnt is combinational, at most one bit high per port, high for exactly the cycle of acceptance.
REQ-017 A request still high in the cycle after its grant SHALL be treated as a new request.
REQ-018 Write and read ports SHALL be arbitrated independently, each by two-way round-robin: the requester granted last loses the next contested cycle; an uncontested request is granted immediately.
REQ-019 After each grant, the port's priority pointer SHALL move to the other requester; with no grant the pointer holds.
REQ-020 Write grant in cycle t SHALL drive ram_wea=1, ram_addra and ram_dina (registered) in cycle t+1; otherwise ram_wea=0 and ram_addra/ram_dina hold their last values.
REQ-021 Read grant in cycle t SHALL register ram_addrb in t+1; rd_valid[i] SHALL be 1 in cycle t+2 with rd_data = ram_doutb (passed through).
REQ-022 Back-to-back reads SHALL sustain one grant per cycle; rd_valid order SHALL equal grant order.
REQ-023 Hazard: if the read address about to be granted equals the write address being granted in the same cycle, the read grant SHALL be withheld that cycle (write wins); the read pointer does not move.
REQ-024 Address arithmetic SHALL be unmodified pass-through; no wrap handling in the arbiter.
REQ-025 Outputs wr_gnt and rd_gnt SHALL be 0 whenever rst is high.

Reset
REQ-026 On rst: ram_wea=0, ram_addra=0, ram_dina=0, ram_addrb=0, rd_valid=0, both pointers favour requester 0.
REQ-027 Reset mid-operation SHALL cancel in-flight reads (no rd_valid after rst) and in-flight writes (ram_wea=0 the cycle after rst).

Structure
REQ-028 Package ram_arb_pkg SHALL hold ADDR_W/DATA_W defaults and the requester count constant (2).
REQ-029 One sub-module rr_arb2 (two-way round-robin, req[1:0] -> gnt[1:0], pointer state) SHALL be instantiated twice, for write and read ports.

Verification
REQ-030 Reset, then wr_req=01, wr_addr0=5, wr_data0=16'hA5A5 -> wr_gnt=01 same cycle; next cycle ram_wea=1, ram_addra=5, ram_dina=16'hA5A5.
REQ-031 wr_req=11 held 4 cycles -> wr_gnt sequence 01,10,01,10.
REQ-032 rd_req=10, rd_addr1=5 after write of A5A5 to address 5 -> rd_gnt=10 at t, ram_addrb=5 at t+1, rd_valid=10 and rd_data=16'hA5A5 at t+2.
REQ-033 Same cycle wr_req=01 addr 7 and rd_req=01 addr 7 -> wr_gnt=01, rd_gnt=00; next cycle rd_gnt=01, and later read returns the new data.
REQ-034 Read grants at t and t+1, rst asserted at t+1 -> rd_valid stays 00 through t+3; all RAM outputs 0 at t+2.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared constants and types for the dual-port RAM arbiter.
// Defaults size a 512 x 16 RAM shared by two requesters.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 16;
    localparam int NUM_REQ    = 2;

    // Round-robin pointer: which requester wins the next contested cycle.
    typedef enum logic {
        PRI_0 = 1'b0,
        PRI_1 = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a combinational grant and a one-bit pointer.
// cand_o is the grant before inhibit_i, so the parent can veto it without a loop.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               inhibit_i,
    output logic [NUM_REQ-1:0] cand_o,
    output logic [NUM_REQ-1:0] gnt_o,
    output rr_ptr_e            ptr_o
);

    rr_ptr_e ptr_q, ptr_d;

    always_comb begin
        cand_o = '0;
        case (req_i)
            2'b01:   cand_o = 2'b01;
            2'b10:   cand_o = 2'b10;
            2'b11:   cand_o = (ptr_q == PRI_1) ? 2'b10 : 2'b01;
            default: cand_o = '0;
        endcase
    end

    always_comb begin
        gnt_o = (rst || inhibit_i) ? '0 : cand_o;
        ptr_d = ptr_q;
        // The winner hands priority to the other requester; a vetoed cycle leaves it alone.
        if (gnt_o[0]) begin
            ptr_d = PRI_1;
        end else if (gnt_o[1]) begin
            ptr_d = PRI_0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= PRI_0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two writers onto RAM port A and two readers onto RAM port B.
// Reads return on rd_data two cycles after grant, tagged by rd_valid.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         wr_req,
    input  logic [ADDR_W-1:0]  wr_addr0,
    input  logic [ADDR_W-1:0]  wr_addr1,
    input  logic [DATA_W-1:0]  wr_data0,
    input  logic [DATA_W-1:0]  wr_data1,
    output logic [1:0]         wr_gnt,
    input  logic [1:0]         rd_req,
    input  logic [ADDR_W-1:0]  rd_addr0,
    input  logic [ADDR_W-1:0]  rd_addr1,
    output logic [1:0]         rd_gnt,
    output logic [1:0]         rd_valid,
    output logic [DATA_W-1:0]  rd_data,
    output logic               ram_wea,
    output logic [ADDR_W-1:0]  ram_addra,
    output logic [DATA_W-1:0]  ram_dina,
    output logic [ADDR_W-1:0]  ram_addrb,
    input  logic [DATA_W-1:0]  ram_doutb,
    output logic [1:0]         dbg_ptr
);

    // Handshake: req/addr/data are held stable until gnt; gnt is combinational and
    // high only in the accepting cycle, and a req still high afterwards is a new request.

    logic [1:0]        wr_cand, rd_cand;
    logic [ADDR_W-1:0] wr_gnt_addr, rd_cand_addr;
    logic [DATA_W-1:0] wr_gnt_data;
    logic              rd_hazard;
    rr_ptr_e           wr_ptr, rd_ptr;

    logic              ram_wea_q, ram_wea_d;
    logic [ADDR_W-1:0] ram_addra_q, ram_addra_d;
    logic [DATA_W-1:0] ram_dina_q, ram_dina_d;
    logic [ADDR_W-1:0] ram_addrb_q, ram_addrb_d;
    logic [1:0]        rd_pend_q, rd_pend_d;
    logic [1:0]        rd_valid_q, rd_valid_d;

    rr_arb2 u_wr_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (wr_req),
        .inhibit_i (1'b0),
        .cand_o    (wr_cand),
        .gnt_o     (wr_gnt),
        .ptr_o     (wr_ptr)
    );

    rr_arb2 u_rd_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (rd_req),
        .inhibit_i (rd_hazard),
        .cand_o    (rd_cand),
        .gnt_o     (rd_gnt),
        .ptr_o     (rd_ptr)
    );

    always_comb begin
        wr_gnt_addr  = wr_gnt[1] ? wr_addr1 : wr_addr0;
        wr_gnt_data  = wr_gnt[1] ? wr_data1 : wr_data0;
        rd_cand_addr = rd_cand[1] ? rd_addr1 : rd_addr0;
        // A read colliding with a same-cycle write waits one cycle so it sees the new data.
        rd_hazard    = (|rd_cand) && (|wr_gnt) && (rd_cand_addr == wr_gnt_addr);
    end

    always_comb begin
        ram_wea_d   = |wr_gnt;
        ram_addra_d = ram_addra_q;
        ram_dina_d  = ram_dina_q;
        ram_addrb_d = ram_addrb_q;
        rd_pend_d   = rd_gnt;
        rd_valid_d  = rd_pend_q;
        if (|wr_gnt) begin
            ram_addra_d = wr_gnt_addr;
            ram_dina_d  = wr_gnt_data;
        end
        if (rd_gnt[1]) begin
            ram_addrb_d = rd_addr1;
        end else if (rd_gnt[0]) begin
            ram_addrb_d = rd_addr0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wea_q   <= 1'b0;
            ram_addra_q <= '0;
            ram_dina_q  <= '0;
            ram_addrb_q <= '0;
            rd_pend_q   <= '0;
            rd_valid_q  <= '0;
        end else begin
            ram_wea_q   <= ram_wea_d;
            ram_addra_q <= ram_addra_d;
            ram_dina_q  <= ram_dina_d;
            ram_addrb_q <= ram_addrb_d;
            rd_pend_q   <= rd_pend_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign ram_wea   = ram_wea_q;
    assign ram_addra = ram_addra_q;
    assign ram_dina  = ram_dina_q;
    assign ram_addrb = ram_addrb_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = ram_doutb;
    assign dbg_ptr   = {rd_ptr, wr_ptr};

endmodule
